// File: rtl/btn_debounce_pulse.sv
// ============================================================================
// Module: btn_debounce_pulse
//
// Purpose
//   Input stage between the raw board pushbuttons and the game controller.
//   Each button channel has its own two-flop synchronizer, debounce FSM,
//   debounced level and a single-cycle press pulse. Every output is in the
//   ClkPort domain.
//
// Optional feature (compile-time macro BTN_AUTOREPEAT_EN)
//   Defined:   btn_mcen carries the press pulse plus auto-repeat pulses while
//              the button stays pressed. The first repeat is REPEAT_DELAY
//              cycles after the press pulse, then one every REPEAT_PERIOD.
//   Undefined: btn_mcen is identical to btn_scen and no repeat counter
//              exists.
//
// Parameters
//   NUM_BTN          number of independent button channels
//   DEBOUNCE_CYCLES  cycles the input must be stable to accept a change (>=2)
//   REPEAT_DELAY     press pulse to first repeat pulse, in cycles (>=2)
//   REPEAT_PERIOD    cycles between later repeat pulses (>=2)
//
// Ports
//   ClkPort    in   1          system clock
//   Reset      in   1          synchronous, active-high; wins over all else
//   btn_raw    in   NUM_BTN    asynchronous bouncy buttons, active-high
//   btn_db     out  NUM_BTN    debounced level (1 in PRESSED / WQ_RELEASE)
//   btn_scen   out  NUM_BTN    one-cycle pulse per accepted press
//   btn_mcen   out  NUM_BTN    press pulse plus optional repeat pulses
//   btn_state  out  2*NUM_BTN  per-channel FSM state, channel i at [2i+1:2i]
//
// FSM encoding (visible on btn_state)
//   IDLE=00, WQ_PRESS=01, PRESSED=10, WQ_RELEASE=11
//   Bit 1 of the state is the debounced level.
// ============================================================================
module btn_debounce_pulse #(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 20_000_000
) (
    input  logic                   ClkPort,
    input  logic                   Reset,
    input  logic [NUM_BTN-1:0]     btn_raw,
    output logic [NUM_BTN-1:0]     btn_db,
    output logic [NUM_BTN-1:0]     btn_scen,
    output logic [NUM_BTN-1:0]     btn_mcen,
    output logic [2*NUM_BTN-1:0]   btn_state
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE       = 2'b00;
    localparam logic [1:0] ST_WQ_PRESS   = 2'b01;
    localparam logic [1:0] ST_PRESSED    = 2'b10;
    localparam logic [1:0] ST_WQ_RELEASE = 2'b11;

    // Debounce counter only ever holds 0..DEBOUNCE_CYCLES-1.
    localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Timing parameters below 2 would make a terminal count of 0, which
    // the counters cannot honour; refuse to elaborate such a build.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
        $error("btn_debounce_pulse: timing parameters must be >= 2");
    end

`ifdef BTN_AUTOREPEAT_EN
    // One repeat counter serves both the initial delay and the period.
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;
    localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD - 1);
`endif

    // ------------------------------------------------------------------
    // Two-flop synchronizer, all channels at once. The FSMs read sync2.
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;

    always_ff @(posedge ClkPort) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce FSM
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic [1:0]      state;
        logic [1:0]      state_nxt;
        logic [DB_W-1:0] cnt;
        logic [DB_W-1:0] cnt_nxt;
        logic            scen_q;
        logic            scen_nxt;

        // Counter is cleared on entry to each wait state and compared
        // against its limit before incrementing, so it can never wrap.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            scen_nxt  = 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sync2[i]) begin
                        state_nxt = ST_WQ_PRESS;
                        cnt_nxt   = '0;
                    end
                end
                ST_WQ_PRESS: begin
                    if (!sync2[i]) begin
                        // Bounce: drop back silently.
                        state_nxt = ST_IDLE;
                    end else if (cnt == DB_LAST) begin
                        state_nxt = ST_PRESSED;
                        scen_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + DB_W'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!sync2[i]) begin
                        state_nxt = ST_WQ_RELEASE;
                        cnt_nxt   = '0;
                    end
                end
                ST_WQ_RELEASE: begin
                    if (sync2[i]) begin
                        // Release glitch: still the same press, no new pulse.
                        state_nxt = ST_PRESSED;
                    end else if (cnt == DB_LAST) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt + DB_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        always_ff @(posedge ClkPort) begin
            if (Reset) begin
                state  <= ST_IDLE;
                cnt    <= '0;
                scen_q <= 1'b0;
            end else begin
                state  <= state_nxt;
                cnt    <= cnt_nxt;
                scen_q <= scen_nxt;
            end
        end

        assign btn_db[i]             = state[1];
        assign btn_scen[i]           = scen_q;
        assign btn_state[2*i +: 2]   = state;

`ifdef BTN_AUTOREPEAT_EN
        // Repeat timer: runs only while the channel stays in PRESSED.
        // rpt_first selects the REPEAT_DELAY limit until the first repeat
        // has fired, REPEAT_PERIOD afterwards. Leaving PRESSED, or any
        // cycle outside it, re-arms the timer, so a re-entry from
        // WQ_RELEASE starts a fresh delay.
        logic [RPT_W-1:0] rcnt;
        logic [RPT_W-1:0] rcnt_nxt;
        logic             rpt_first;
        logic             rpt_first_nxt;
        logic             rpt_nxt;
        logic             mcen_q;

        always_comb begin
            rcnt_nxt      = '0;
            rpt_first_nxt = 1'b1;
            rpt_nxt       = 1'b0;
            if (state == ST_PRESSED && state_nxt == ST_PRESSED) begin
                rpt_first_nxt = rpt_first;
                if (rpt_first && rcnt == RD_LAST) begin
                    rpt_nxt       = 1'b1;
                    rpt_first_nxt = 1'b0;
                end else if (!rpt_first && rcnt == RP_LAST) begin
                    rpt_nxt = 1'b1;
                end else begin
                    rcnt_nxt = rcnt + RPT_W'(1);
                end
            end
        end

        always_ff @(posedge ClkPort) begin
            if (Reset) begin
                rcnt      <= '0;
                rpt_first <= 1'b1;
                mcen_q    <= 1'b0;
            end else begin
                rcnt      <= rcnt_nxt;
                rpt_first <= rpt_first_nxt;
                mcen_q    <= scen_nxt | rpt_nxt;
            end
        end

        assign btn_mcen[i] = mcen_q;
`else
        assign btn_mcen[i] = scen_q;
`endif
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// ============================================================================
// Bench for btn_debounce_pulse with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=5. A behavioural model (stable-run counting per channel)
// predicts every output each cycle into exp_q; a compare process checks the
// DUT against it on each falling edge. Directed literal checks pin the model.
// ============================================================================
module tb_btn_debounce_pulse;

    localparam int NB  = 5;
    localparam int DB  = 4;
    localparam int RD  = 10;
    localparam int RP  = 5;
    localparam int EW  = 5 * NB;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_db;
    logic [NB-1:0] btn_scen;
    logic [NB-1:0] btn_mcen;
    logic [2*NB-1:0] btn_state;

    always #5 clk = ~clk;

    btn_debounce_pulse #(
        .NUM_BTN         (NB),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .ClkPort   (clk),
        .Reset     (rst),
        .btn_raw   (btn_raw),
        .btn_db    (btn_db),
        .btn_scen  (btn_scen),
        .btn_mcen  (btn_mcen),
        .btn_state (btn_state)
    );

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------------------------
    // Behavioural model: a channel's accepted level changes once the
    // synchronized input has disagreed with it for DB+1 consecutive
    // samples. The debouncer sees the raw input two edges late.
    // ------------------------------------------------------------------
    logic [EW-1:0]  exp_q[$];
    logic [NB-1:0]  raw_d1;
    logic [NB-1:0]  raw_d2;
    bit             lvl  [NB];
    int             run  [NB];
    int             held [NB];

    always @(posedge clk) begin
        logic [NB-1:0]   seen;
        logic [2*NB-1:0] e_st;
        logic [NB-1:0]   e_db;
        logic [NB-1:0]   e_sc;
        logic [NB-1:0]   e_mc;
        bit              pulse;
        bit              was_pressed;
        bit              now_pressed;
        e_st = '0;
        e_db = '0;
        e_sc = '0;
        e_mc = '0;
        if (rst) begin
            raw_d1 = '0;
            raw_d2 = '0;
            for (int c = 0; c < NB; c++) begin
                lvl[c]  = 1'b0;
                run[c]  = 0;
                held[c] = 0;
            end
        end else begin
            seen   = raw_d2;
            raw_d2 = raw_d1;
            raw_d1 = btn_raw;
            for (int c = 0; c < NB; c++) begin
                was_pressed = lvl[c] && (run[c] == 0);
                pulse = 1'b0;
                if (seen[c] != lvl[c]) begin
                    run[c] = run[c] + 1;
                    if (run[c] == DB + 1) begin
                        lvl[c] = seen[c];
                        run[c] = 0;
                        pulse  = seen[c];
                    end
                end else begin
                    run[c] = 0;
                end
                now_pressed = lvl[c] && (run[c] == 0);
                if (now_pressed) held[c] = was_pressed ? held[c] + 1 : 0;
                else             held[c] = 0;
                e_st[2*c +: 2] = {lvl[c], run[c] != 0};
                e_db[c] = lvl[c];
                e_sc[c] = pulse;
`ifdef BTN_AUTOREPEAT_EN
                e_mc[c] = pulse | (now_pressed && held[c] >= RD && ((held[c] - RD) % RP) == 0);
`else
                e_mc[c] = pulse;
`endif
            end
        end
        exp_q.push_back({e_st, e_db, e_sc, e_mc});
    end

    // ------------------------------------------------------------------
    // Scoreboard compare: every cycle, away from the active edge
    // ------------------------------------------------------------------
    int cyc = 0;
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {btn_state, btn_db, btn_scen, btn_mcen};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL model_cycle%0d: got state=%h db=%h scen=%h mcen=%h want state=%h db=%h scen=%h mcen=%h",
                         cyc, a[EW-1 -: 2*NB], a[3*NB-1 -: NB], a[2*NB-1 -: NB], a[NB-1:0],
                         e[EW-1 -: 2*NB], e[3*NB-1 -: NB], e[2*NB-1 -: NB], e[NB-1:0]);
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks and literal checks
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic release_all();
        btn_raw = '0;
        tick(10);
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] bounce;
        bounce  = 8'b1101_0110;   // applied MSB first: 1,1,0,1,0,1,1,0
        rst     = 1'b1;
        btn_raw = 5'h1F;

        // 1: buttons held through reset
        tick(1);
        check("t1_rst_scen",  32'(btn_scen),  32'h0);
        check("t1_rst_db",    32'(btn_db),    32'h0);
        check("t1_rst_mcen",  32'(btn_mcen),  32'h0);
        tick(1);
        check("t1_rst_state", 32'(btn_state), 32'h0);
        rst = 1'b0;
        tick(6);
        check("t1_wq_state",  32'(btn_state), 32'h155);
        check("t1_early",     32'(btn_scen),  32'h0);
        tick(1);
        check("t1_scen",      32'(btn_scen),  32'h1F);
        check("t1_db",        32'(btn_db),    32'h1F);
        check("t1_mcen",      32'(btn_mcen),  32'h1F);
        check("t1_pr_state",  32'(btn_state), 32'h2AA);
        tick(1);
        check("t1_scen_off",  32'(btn_scen),  32'h0);
        btn_raw = '0;
        tick(6);
        check("t1_rel_state", 32'(btn_state), 32'h3FF);
        tick(1);
        check("t1_rel_db",    32'(btn_db),    32'h0);
        tick(4);

        // 2: single press on channel 0, held 20 cycles
        btn_raw = 5'b00001;
        tick(6);
        check("t2_early",     32'(btn_scen),  32'h0);
        tick(1);
        check("t2_scen",      32'(btn_scen),  32'h01);
        check("t2_db",        32'(btn_db),    32'h01);
        tick(13);
        btn_raw = '0;
        tick(6);
        check("t2_db_hold",   32'(btn_db),    32'h01);
        tick(1);
        check("t2_db_fall",   32'(btn_db),    32'h0);
        check("t2_no_rel_pulse", 32'(btn_scen), 32'h0);
        tick(4);

        // 3: bounce on channel 2, then steady
        for (int b = 7; b >= 0; b--) begin
            btn_raw[2] = bounce[b];
            tick(1);
            check("t3_bounce", 32'(btn_scen), 32'h0);
        end
        btn_raw[2] = 1'b1;
        tick(6);
        check("t3_early",     32'(btn_scen),  32'h0);
        tick(1);
        check("t3_scen",      32'(btn_scen),  32'h04);
        tick(1);
        check("t3_scen_off",  32'(btn_scen),  32'h0);
        release_all();

        // 4: two channels rise together
        btn_raw = 5'b01010;
        tick(7);
        check("t4_scen",      32'(btn_scen),  32'h0A);
        tick(1);
        check("t4_scen_off",  32'(btn_scen),  32'h0);
        release_all();

        // 5: reset during WQ_PRESS, then a short release glitch
        btn_raw = 5'b00001;
        tick(3);
        check("t5_wq_state",  32'(btn_state[1:0]), 32'h1);
        rst = 1'b1;
        tick(1);
        check("t5_rst_state", 32'(btn_state), 32'h0);
        check("t5_rst_scen",  32'(btn_scen),  32'h0);
        rst = 1'b0;
        tick(6);
        check("t5_early",     32'(btn_scen),  32'h0);
        tick(1);
        check("t5_scen",      32'(btn_scen),  32'h01);
        tick(2);
        btn_raw[0] = 1'b0;
        tick(2);
        btn_raw[0] = 1'b1;
        tick(1);
        check("t5_glitch_state", 32'(btn_state[1:0]), 32'h3);
        check("t5_glitch_db",    32'(btn_db),         32'h01);
        tick(2);
        check("t5_back_state",   32'(btn_state[1:0]), 32'h2);
        check("t5_no_scen",      32'(btn_scen),       32'h0);
        release_all();

        // 6: long hold on channel 4, repeat schedule
        btn_raw = 5'b10000;
        tick(7);
        check("t6_scen",      32'(btn_scen),  32'h10);
        check("t6_mcen_p",    32'(btn_mcen),  32'h10);
        tick(1);
        check("t6_mcen_p1",   32'(btn_mcen),  32'h0);
        tick(8);
        check("t6_mcen_p9",   32'(btn_mcen),  32'h0);
        tick(1);
`ifdef BTN_AUTOREPEAT_EN
        check("t6_mcen_p10",  32'(btn_mcen),  32'h10);
        tick(5);
        check("t6_mcen_p15",  32'(btn_mcen),  32'h10);
        tick(5);
        check("t6_mcen_p20",  32'(btn_mcen),  32'h10);
`else
        check("t6_mcen_p10",  32'(btn_mcen),  32'h0);
        tick(5);
        check("t6_mcen_p15",  32'(btn_mcen),  32'h0);
        tick(5);
        check("t6_mcen_p20",  32'(btn_mcen),  32'h0);
`endif
        check("t6_scen_once", 32'(btn_scen),  32'h0);
        tick(13);
        release_all();

        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
